// File: rtl/mpsoc_wb_mpram_arbiter.sv
// rtl/mpsoc_wb_mpram_arbiter.sv - round-robin Wishbone arbiter sharing one SPRAM slave
// Optional unacknowledged-strobe watchdog: define MPSOC_WB_MPRAM_ARB_WATCHDOG_EN.
module mpsoc_wb_mpram_arbiter #(
    parameter int MASTERS = 4,
    parameter int AW      = 8,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_ni,
    input  logic [MASTERS*AW-1:0] m_adr_i,
    input  logic [MASTERS*DW-1:0] m_dat_i,
    input  logic [MASTERS*4-1:0]  m_sel_i,
    input  logic [MASTERS-1:0]    m_we_i,
    input  logic [MASTERS-1:0]    m_cyc_i,
    input  logic [MASTERS-1:0]    m_stb_i,
    input  logic [MASTERS*3-1:0]  m_cti_i,
    input  logic [MASTERS*2-1:0]  m_bte_i,
    output logic [MASTERS-1:0]    m_ack_o,
    output logic [MASTERS-1:0]    m_err_o,
    output logic [MASTERS*DW-1:0] m_dat_o,
    output logic [AW-1:0]         s_adr_o,
    output logic [DW-1:0]         s_dat_o,
    output logic [3:0]            s_sel_o,
    output logic                  s_we_o,
    output logic [2:0]            s_cti_o,
    output logic [1:0]            s_bte_o,
    output logic                  s_cyc_o,
    output logic                  s_stb_o,
    input  logic                  s_ack_i,
    input  logic                  s_err_i,
    input  logic [DW-1:0]         s_dat_i,
    output logic [MASTERS-1:0]    grant_o
);

    localparam int IW = (MASTERS > 1) ? $clog2(MASTERS) : 1;

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    logic [MASTERS-1:0] grant, grant_nxt;
    logic [IW-1:0]      rr_ptr, ptr_nxt, owner, owner_inc;
    state_t             state;
    logic               wd_err;

    // First requester at or after ptr, wrapping; iterating downward lets the nearest win.
    function automatic logic [MASTERS-1:0] rr_pick(input logic [MASTERS-1:0] req,
                                                   input logic [IW-1:0] ptr);
        logic [IW-1:0] idx;
        rr_pick = '0;
        for (int i = MASTERS - 1; i >= 0; i--) begin
            idx = IW'((int'(ptr) + i) % MASTERS);
            if (req[idx]) begin
                rr_pick      = '0;
                rr_pick[idx] = 1'b1;
            end
        end
    endfunction

    always_comb begin
        owner = '0;
        for (int k = 0; k < MASTERS; k++) begin
            if (grant[k]) owner = IW'(k);
        end
        state     = (grant != '0) ? BUSY : IDLE;
        owner_inc = (owner == IW'(MASTERS - 1)) ? '0 : owner + 1'b1;
    end

    always_comb begin
        grant_nxt = grant;
        ptr_nxt   = rr_ptr;
        case (state)
            IDLE: grant_nxt = rr_pick(m_cyc_i, rr_ptr);
            BUSY: begin
                // Releasing owner goes to the back of the queue; its cyc is already low.
                if (!m_cyc_i[owner]) begin
                    ptr_nxt   = owner_inc;
                    grant_nxt = rr_pick(m_cyc_i, owner_inc);
                end
            end
            default: grant_nxt = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            grant  <= '0;
            rr_ptr <= '0;
        end else begin
            grant  <= grant_nxt;
            rr_ptr <= ptr_nxt;
        end
    end

    always_comb begin
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        s_we_o  = 1'b0;
        s_cti_o = '0;
        s_bte_o = '0;
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        if (state == BUSY) begin
            s_adr_o = m_adr_i[owner*AW +: AW];
            s_dat_o = m_dat_i[owner*DW +: DW];
            s_sel_o = m_sel_i[owner*4 +: 4];
            s_we_o  = m_we_i[owner];
            s_cti_o = m_cti_i[owner*3 +: 3];
            s_bte_o = m_bte_i[owner*2 +: 2];
            s_cyc_o = m_cyc_i[owner];
            s_stb_o = m_stb_i[owner];
        end
    end

    assign m_ack_o = grant & {MASTERS{s_ack_i}};
    assign m_err_o = grant & {MASTERS{s_err_i | wd_err}};
    assign m_dat_o = {MASTERS{s_dat_i}};
    assign grant_o = grant;

`ifdef MPSOC_WB_MPRAM_ARB_WATCHDOG_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] wd_cnt;
    logic          wd_stall;

    assign wd_stall = s_cyc_o & s_stb_o & !s_ack_i & !s_err_i;
    assign wd_err   = s_cyc_o & s_stb_o & (wd_cnt == TW'(TIMEOUT));

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wd_cnt <= '0;
        end else if (!wd_stall || wd_err || (grant_nxt != grant)) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end
`else
    assign wd_err = 1'b0;
`endif

endmodule
